// File: rtl/mc_control.sv
// mc_control: multicycle main control FSM for the MIPS-subset CPU.
//
// Sequences each instruction through fetch, decode, execute, memory and
// writeback steps. It drives the datapath enables and mux selects, and it
// counts retired instructions.
//
// Parameters:
//   CNT_W        width of the retired-instruction counter
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   opcode       IR[31:26], used in DECODE and MEMADR
//   mem_ready    memory handshake; an access completes in a cycle where it is 1
//   pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
//   memtoreg, regdst, regwrite, alusrca      datapath controls
//   alusrcb      ALU B select (00 reg B, 01 const 4, 10 sext imm, 11 imm<<2)
//   aluop        to ALU control (00 add, 01 sub, 1x decode funct)
//   pcsrc        PC select (00 ALU result, 01 ALUOut, 10 jump target)
//   illegal      one-cycle pulse in TRAP
//   instr_done   one-cycle pulse in the last state of each legal instruction
//   instret      retired-instruction count, wraps at 2^CNT_W
module mc_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             memtoreg,
  output logic             regdst,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsrc,
  output logic             illegal,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret
);

  // Opcodes
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  // FSM states
  localparam logic [3:0] StFetch  = 4'd0;
  localparam logic [3:0] StDecode = 4'd1;
  localparam logic [3:0] StMemAdr = 4'd2;
  localparam logic [3:0] StMemRd  = 4'd3;
  localparam logic [3:0] StMemWb  = 4'd4;
  localparam logic [3:0] StMemWr  = 4'd5;
  localparam logic [3:0] StRtExec = 4'd6;
  localparam logic [3:0] StRtWb   = 4'd7;
  localparam logic [3:0] StBranch = 4'd8;
  localparam logic [3:0] StJump   = 4'd9;
  localparam logic [3:0] StAddiEx = 4'd10;
  localparam logic [3:0] StAddiWb = 4'd11;
  localparam logic [3:0] StTrap   = 4'd12;

  // ALU B selects
  localparam logic [1:0] SrcbReg   = 2'b00;
  localparam logic [1:0] SrcbFour  = 2'b01;
  localparam logic [1:0] SrcbImm   = 2'b10;
  localparam logic [1:0] SrcbImmSh = 2'b11;

  // ALU ops
  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  // PC sources
  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic             done;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        case (opcode)
          OpRtype:    state_d = StRtExec;
          OpLw, OpSw: state_d = StMemAdr;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StAddiEx;
          default:    state_d = StTrap;
        endcase
      end
      // The IR does not change after FETCH, so re-reading opcode here is safe.
      StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd: begin
        if (mem_ready) state_d = StMemWb;
      end
      StMemWr: begin
        if (mem_ready) state_d = StFetch;
      end
      StRtExec: state_d = StRtWb;
      StAddiEx: state_d = StAddiWb;
      StMemWb, StRtWb, StBranch, StJump, StAddiWb, StTrap: state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // Moore outputs; FETCH and MEMWR additionally gate on mem_ready.
  // Everything is held at 0 while rst is high, so an instruction cut off by
  // reset performs no writes in that cycle.
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = SrcbReg;
    aluop       = AluAdd;
    pcsrc       = PcAlu;
    illegal     = 1'b0;
    done        = 1'b0;
    if (!rst) begin
      case (state_q)
        StFetch: begin
          memread = 1'b1;
          alusrcb = SrcbFour;
          aluop   = AluAdd;
          pcsrc   = PcAlu;
          // PC and IR update exactly once per fetch, on the ready cycle.
          irwrite = mem_ready;
          pcwrite = mem_ready;
        end
        StDecode: begin
          // Branch target into ALUOut ahead of a possible beq.
          alusrcb = SrcbImmSh;
          aluop   = AluAdd;
        end
        StMemAdr: begin
          alusrca = 1'b1;
          alusrcb = SrcbImm;
          aluop   = AluAdd;
        end
        StMemRd: begin
          memread = 1'b1;
          iord    = 1'b1;
        end
        StMemWb: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
          regdst   = 1'b0;
          done     = 1'b1;
        end
        StMemWr: begin
          memwrite = 1'b1;
          iord     = 1'b1;
          done     = mem_ready;
        end
        StRtExec: begin
          alusrca = 1'b1;
          alusrcb = SrcbReg;
          aluop   = AluFunct;
        end
        StRtWb: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
          done     = 1'b1;
        end
        StBranch: begin
          alusrca     = 1'b1;
          alusrcb     = SrcbReg;
          aluop       = AluSub;
          pcwritecond = 1'b1;
          pcsrc       = PcAluOut;
          done        = 1'b1;
        end
        StJump: begin
          pcwrite = 1'b1;
          pcsrc   = PcJump;
          done    = 1'b1;
        end
        StAddiEx: begin
          alusrca = 1'b1;
          alusrcb = SrcbImm;
          aluop   = AluAdd;
        end
        StAddiWb: begin
          regwrite = 1'b1;
          regdst   = 1'b0;
          done     = 1'b1;
        end
        StTrap: begin
          illegal = 1'b1;
        end
        default: begin
          illegal = 1'b0;
        end
      endcase
    end
  end

  assign instr_done = done;
  assign instret    = rst ? '0 : instret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (done) instret_q <= instret_q + CntOne;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;

  localparam int unsigned CW = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // Control word layout:
  // {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
  //  regdst, regwrite, alusrca, alusrcb[1:0], aluop[1:0], pcsrc[1:0],
  //  illegal, instr_done}
  localparam logic [17:0] B_PCWRITE  = 18'd1 << 17;
  localparam logic [17:0] B_PCWC     = 18'd1 << 16;
  localparam logic [17:0] B_IORD     = 18'd1 << 15;
  localparam logic [17:0] B_MEMREAD  = 18'd1 << 14;
  localparam logic [17:0] B_MEMWRITE = 18'd1 << 13;
  localparam logic [17:0] B_IRWRITE  = 18'd1 << 12;
  localparam logic [17:0] B_MEMTOREG = 18'd1 << 11;
  localparam logic [17:0] B_REGDST   = 18'd1 << 10;
  localparam logic [17:0] B_REGWRITE = 18'd1 << 9;
  localparam logic [17:0] B_ALUSRCA  = 18'd1 << 8;
  localparam logic [17:0] SRCB_4     = 18'd1 << 6;
  localparam logic [17:0] SRCB_IMM   = 18'd2 << 6;
  localparam logic [17:0] SRCB_SH    = 18'd3 << 6;
  localparam logic [17:0] OP_SUBF    = 18'd1 << 4;
  localparam logic [17:0] OP_FUNCTF  = 18'd2 << 4;
  localparam logic [17:0] PC_OUT     = 18'd1 << 2;
  localparam logic [17:0] PC_JMP     = 18'd2 << 2;
  localparam logic [17:0] B_ILLEGAL  = 18'd1 << 1;
  localparam logic [17:0] B_DONE     = 18'd1;

  localparam logic [17:0] C_ZERO        = 18'd0;
  localparam logic [17:0] C_FETCH       = B_MEMREAD | B_IRWRITE | B_PCWRITE | SRCB_4;
  localparam logic [17:0] C_FETCH_STALL = B_MEMREAD | SRCB_4;
  localparam logic [17:0] C_DECODE      = SRCB_SH;
  localparam logic [17:0] C_MEMADR      = B_ALUSRCA | SRCB_IMM;
  localparam logic [17:0] C_MEMRD       = B_MEMREAD | B_IORD;
  localparam logic [17:0] C_MEMWB       = B_REGWRITE | B_MEMTOREG | B_DONE;
  localparam logic [17:0] C_MEMWR       = B_MEMWRITE | B_IORD | B_DONE;
  localparam logic [17:0] C_MEMWR_STALL = B_MEMWRITE | B_IORD;
  localparam logic [17:0] C_RTEXEC      = B_ALUSRCA | OP_FUNCTF;
  localparam logic [17:0] C_RTWB        = B_REGWRITE | B_REGDST | B_DONE;
  localparam logic [17:0] C_BRANCH      = B_ALUSRCA | OP_SUBF | B_PCWC | PC_OUT | B_DONE;
  localparam logic [17:0] C_JUMP        = B_PCWRITE | PC_JMP | B_DONE;
  localparam logic [17:0] C_ADDIEX      = B_ALUSRCA | SRCB_IMM;
  localparam logic [17:0] C_ADDIWB      = B_REGWRITE | B_DONE;
  localparam logic [17:0] C_TRAP        = B_ILLEGAL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    opcode = OP_R;
  logic          mem_ready = 1'b1;
  logic          pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic          memtoreg, regdst, regwrite, alusrca, illegal, instr_done;
  logic [1:0]    alusrcb, aluop, pcsrc;
  logic [CW-1:0] instret;
  logic [17:0]   act;

  always #5 clk = ~clk;

  mc_control #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .pcwrite     (pcwrite),
    .pcwritecond (pcwritecond),
    .iord        (iord),
    .memread     (memread),
    .memwrite    (memwrite),
    .irwrite     (irwrite),
    .memtoreg    (memtoreg),
    .regdst      (regdst),
    .regwrite    (regwrite),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .aluop       (aluop),
    .pcsrc       (pcsrc),
    .illegal     (illegal),
    .instr_done  (instr_done),
    .instret     (instret)
  );

  assign act = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
                regdst, regwrite, alusrca, alusrcb, aluop, pcsrc, illegal, instr_done};

  typedef struct packed {
    logic          rst;
    logic [5:0]    op;
    logic          rdy;
    logic [17:0]   ctl;
    logic [CW-1:0] cnt;
  } vec_t;

  typedef struct packed {
    logic [17:0]   ctl;
    logic [CW-1:0] cnt;
  } exp_t;

  vec_t          vecs[$];
  string         vnames[$];
  exp_t          exp_q[$];
  string         name_q[$];
  logic [CW-1:0] cnt_model = '0;
  int            n_run = 0;
  int            n_fail = 0;

  // Expected instret: 0 while in reset, otherwise the retired count so far,
  // bumped after every cycle that shows instr_done.
  task automatic add(input logic r, input logic [5:0] op, input logic rdy,
                     input logic [17:0] ctl, input string nm);
    vec_t v;
    v.rst = r;
    v.op  = op;
    v.rdy = rdy;
    v.ctl = ctl;
    v.cnt = r ? '0 : cnt_model;
    vecs.push_back(v);
    vnames.push_back(nm);
    if (r) cnt_model = '0;
    else if (ctl[0]) cnt_model = cnt_model + 1'b1;
  endtask

  exp_t  mon_e;
  string mon_nm;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      n_run++;
      if (act !== mon_e.ctl) begin
        n_fail++;
        $display("FAIL %s ctl: got %b want %b", mon_nm, act, mon_e.ctl);
      end
      n_run++;
      if (instret !== mon_e.cnt) begin
        n_fail++;
        $display("FAIL %s instret: got %0d want %0d", mon_nm, instret, mon_e.cnt);
      end
    end
  end

  initial begin
    exp_t ex;

    // Reset
    add(1'b1, OP_R, 1'b1, C_ZERO, "reset0");
    add(1'b1, OP_R, 1'b1, C_ZERO, "reset1");
    // R-type
    add(1'b0, OP_R, 1'b1, C_FETCH,  "r_fetch");
    add(1'b0, OP_R, 1'b1, C_DECODE, "r_decode");
    add(1'b0, OP_R, 1'b1, C_RTEXEC, "r_exec");
    add(1'b0, OP_R, 1'b1, C_RTWB,   "r_wb");
    // lw with 2 fetch stalls and 3 read stalls: 10 cycles
    add(1'b0, OP_LW, 1'b0, C_FETCH_STALL, "lw_fstall0");
    add(1'b0, OP_LW, 1'b0, C_FETCH_STALL, "lw_fstall1");
    add(1'b0, OP_LW, 1'b1, C_FETCH,       "lw_fetch");
    add(1'b0, OP_LW, 1'b1, C_DECODE,      "lw_decode");
    add(1'b0, OP_LW, 1'b1, C_MEMADR,      "lw_memadr");
    add(1'b0, OP_LW, 1'b0, C_MEMRD,       "lw_rdstall0");
    add(1'b0, OP_LW, 1'b0, C_MEMRD,       "lw_rdstall1");
    add(1'b0, OP_LW, 1'b0, C_MEMRD,       "lw_rdstall2");
    add(1'b0, OP_LW, 1'b1, C_MEMRD,       "lw_rd");
    add(1'b0, OP_LW, 1'b1, C_MEMWB,       "lw_wb");
    // beq then sw
    add(1'b0, OP_BEQ, 1'b1, C_FETCH,  "beq_fetch");
    add(1'b0, OP_BEQ, 1'b1, C_DECODE, "beq_decode");
    add(1'b0, OP_BEQ, 1'b1, C_BRANCH, "beq_branch");
    add(1'b0, OP_SW,  1'b1, C_FETCH,  "sw_fetch");
    add(1'b0, OP_SW,  1'b1, C_DECODE, "sw_decode");
    add(1'b0, OP_SW,  1'b1, C_MEMADR, "sw_memadr");
    add(1'b0, OP_SW,  1'b1, C_MEMWR,  "sw_memwr");
    // Illegal opcode, then addi with mem_ready low where it must be ignored
    add(1'b0, OP_BAD,  1'b1, C_FETCH,  "bad_fetch");
    add(1'b0, OP_BAD,  1'b1, C_DECODE, "bad_decode");
    add(1'b0, OP_BAD,  1'b1, C_TRAP,   "bad_trap");
    add(1'b0, OP_ADDI, 1'b1, C_FETCH,  "addi_fetch");
    add(1'b0, OP_ADDI, 1'b0, C_DECODE, "addi_decode");
    add(1'b0, OP_ADDI, 1'b0, C_ADDIEX, "addi_ex");
    add(1'b0, OP_ADDI, 1'b1, C_ADDIWB, "addi_wb");
    // Reset during a MEMWR stall abandons the store
    add(1'b0, OP_SW, 1'b1, C_FETCH,       "sw2_fetch");
    add(1'b0, OP_SW, 1'b1, C_DECODE,      "sw2_decode");
    add(1'b0, OP_SW, 1'b1, C_MEMADR,      "sw2_memadr");
    add(1'b0, OP_SW, 1'b0, C_MEMWR_STALL, "sw2_wrstall");
    add(1'b1, OP_SW, 1'b0, C_ZERO,        "sw2_reset");
    // 16 jumps wrap the 4-bit counter back to 0
    for (int k = 0; k < 16; k++) begin
      add(1'b0, OP_J, 1'b1, C_FETCH,  "j_fetch");
      add(1'b0, OP_J, 1'b1, C_DECODE, "j_decode");
      add(1'b0, OP_J, 1'b1, C_JUMP,   "j_jump");
    end
    add(1'b0, OP_R, 1'b1, C_FETCH, "wrap_fetch");

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rst       = vecs[i].rst;
      opcode    = vecs[i].op;
      mem_ready = vecs[i].rdy;
      ex.ctl    = vecs[i].ctl;
      ex.cnt    = vecs[i].cnt;
      exp_q.push_back(ex);
      name_q.push_back(vnames[i]);
    end
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
